// File: rtl/booth_pkg.sv
// booth_pkg: shared definitions for the radix-2 Booth multiplier controller.
//   N        - operand width; the datapath counter loads this value on ldC
//   ALU_*    - add_sub encodings presented to the datapath ALU
//   state_t  - controller state encoding
//   ctrl_t   - bundle of every strobe the controller drives
//   decode() - Moore output decode for one state
package booth_pkg;

  localparam int unsigned N = 4;

  localparam logic ALU_ADD = 1'b1;
  localparam logic ALU_SUB = 1'b0;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    LOAD   = 4'd1,
    WAIT   = 4'd2,
    CHECK  = 4'd3,
    ADD    = 4'd4,
    SUB    = 4'd5,
    SHIFT  = 4'd6,
    SETTLE = 4'd7,
    DONE   = 4'd8
  } state_t;

  typedef struct packed {
    logic ldA;
    logic clrA;
    logic sftA;
    logic ldQ;
    logic clrQ;
    logic sftQ;
    logic ldM;
    logic clrff;
    logic enf;
    logic add_sub;
    logic ldC;
    logic dec;
    logic busy;
    logic done;
  } ctrl_t;

  function automatic ctrl_t decode(input state_t s);
    ctrl_t c;
    c         = '0;
    c.add_sub = ALU_SUB;
    case (s)
      LOAD: begin
        c.ldQ   = 1'b1;
        c.ldM   = 1'b1;
        c.clrA  = 1'b1;
        c.clrff = 1'b1;
        c.ldC   = 1'b1;
        c.busy  = 1'b1;
      end
      WAIT, CHECK, SETTLE: c.busy = 1'b1;
      ADD: begin
        c.ldA     = 1'b1;
        c.add_sub = ALU_ADD;
        c.busy    = 1'b1;
      end
      SUB: begin
        c.ldA     = 1'b1;
        c.add_sub = ALU_SUB;
        c.busy    = 1'b1;
      end
      SHIFT: begin
        c.sftA = 1'b1;
        c.sftQ = 1'b1;
        c.enf  = 1'b1;
        c.dec  = 1'b1;
        c.busy = 1'b1;
      end
      DONE:    c.done = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/booth_controller.sv
// booth_controller: Moore FSM sequencing a radix-2 Booth multiplier datapath.
// Ports:
//   clk, rst            - clock (rising edge), asynchronous active-high reset
//   start               - multiply request, sampled only in IDLE
//   q0, qm1, eqz        - registered Q[0], Q-1 flop, counter==0 from datapath
//   ldA/clrA/sftA       - A register load / clear / arithmetic right shift
//   ldQ/clrQ/sftQ       - Q register load / clear / shift
//   ldM                 - M register load
//   clrff/enf           - Q-1 flop clear / capture enable
//   add_sub             - ALU op, 1 = A+M, 0 = A-M
//   ldC/dec             - counter load N / decrement
//   busy                - high in every state except IDLE and DONE
//   done                - one-cycle completion pulse
module booth_controller
  import booth_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic q0,
  input  logic qm1,
  input  logic eqz,
  output logic ldA,
  output logic clrA,
  output logic sftA,
  output logic ldQ,
  output logic clrQ,
  output logic sftQ,
  output logic ldM,
  output logic clrff,
  output logic enf,
  output logic add_sub,
  output logic ldC,
  output logic dec,
  output logic busy,
  output logic done
);

  state_t r_state;
  state_t w_next;
  ctrl_t  r_ctrl;

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:   if (start) w_next = LOAD;
      LOAD:   w_next = WAIT;
      WAIT:   w_next = CHECK;
      CHECK: begin
        case ({q0, qm1})
          2'b10:   w_next = SUB;
          2'b01:   w_next = ADD;
          default: w_next = SHIFT;
        endcase
      end
      ADD:    w_next = SHIFT;
      SUB:    w_next = SHIFT;
      SHIFT:  w_next = SETTLE;
      SETTLE: w_next = eqz ? DONE : CHECK;
      DONE:   w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Strobes are registered from the decode of the next state, so they track
  // the current state exactly (Moore) while coming straight out of flops;
  // the async reset clears them together with the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ctrl  <= '0;
    end else begin
      r_state <= w_next;
      r_ctrl  <= decode(w_next);
    end
  end

  assign ldA     = r_ctrl.ldA;
  assign clrA    = r_ctrl.clrA;
  assign sftA    = r_ctrl.sftA;
  assign ldQ     = r_ctrl.ldQ;
  assign clrQ    = r_ctrl.clrQ;
  assign sftQ    = r_ctrl.sftQ;
  assign ldM     = r_ctrl.ldM;
  assign clrff   = r_ctrl.clrff;
  assign enf     = r_ctrl.enf;
  assign add_sub = r_ctrl.add_sub;
  assign ldC     = r_ctrl.ldC;
  assign dec     = r_ctrl.dec;
  assign busy    = r_ctrl.busy;
  assign done    = r_ctrl.done;

endmodule

// File: tb/tb_booth_controller.sv
// tb_booth_controller: bench for booth_controller with a behavioural Booth
// datapath around it; results are checked against signed arithmetic and the
// bit-pair rules for operation order and latency.
module tb_booth_controller;
  import booth_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic q0, qm1, eqz;
  logic ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, enf, add_sub, ldC, dec, busy, done;

  always #5 clk = ~clk;

  booth_controller dut (
    .clk(clk), .rst(rst), .start(start), .q0(q0), .qm1(qm1), .eqz(eqz),
    .ldA(ldA), .clrA(clrA), .sftA(sftA), .ldQ(ldQ), .clrQ(clrQ), .sftQ(sftQ),
    .ldM(ldM), .clrff(clrff), .enf(enf), .add_sub(add_sub), .ldC(ldC),
    .dec(dec), .busy(busy), .done(done)
  );

  wire [13:0] all_out = {ldA, clrA, sftA, ldQ, clrQ, sftQ, ldM, clrff, enf,
                         add_sub, ldC, dec, busy, done};

  // Behavioural datapath driven by the controller strobes.
  logic [3:0] tb_m, tb_q;
  logic [3:0] dA = '0, dQ = '0, dM = '0;
  logic       dqm1 = 1'b0;
  int         dcnt = 0;

  always @(posedge clk) begin
    if (clrA)      dA <= '0;
    else if (ldA)  dA <= add_sub ? dA + dM : dA - dM;
    else if (sftA) dA <= {dA[3], dA[3:1]};
    if (ldQ)       dQ <= tb_q;
    else if (sftQ) dQ <= {dA[0], dQ[3:1]};
    if (ldM)       dM <= tb_m;
    if (clrff)     dqm1 <= 1'b0;
    else if (enf)  dqm1 <= dQ[0];
    if (ldC)       dcnt <= N;
    else if (dec)  dcnt <= dcnt - 1;
  end

  assign q0  = dQ[0];
  assign qm1 = dqm1;
  assign eqz = (dcnt == 0);

  // Protocol monitor: illegal strobe overlaps and busy/done together.
  int viol = 0;
  always @(negedge clk) begin
    if (!rst) begin
      if ((ldA && sftA) || (ldQ && sftQ) || (clrA && ldA) || (clrQ && ldQ) ||
          (busy && done))
        viol++;
    end
  end

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 = single start pulse, 1 = start held high, 2 = start toggled while busy
  task automatic run_mult(input logic [3:0] m, input logic [3:0] q, input int mode,
                          input string tag, output int waits);
    int         cyc, shifts, nops, k, sm, sq;
    logic [7:0] obs_ops, exp_ops, exp_prod;
    logic       prev;
    bit         got;

    got   = 0;
    waits = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      waits++;
      if (!busy && !done) begin
        got = 1;
        break;
      end
    end
    chk({tag, " idle"}, 32'(got), 32'd1);

    tb_m  = m;
    tb_q  = q;
    start = 1'b1;
    @(posedge clk);

    cyc = 0; shifts = 0; nops = 0; obs_ops = '0; got = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      cyc++;
      if (mode == 0)      start = 1'b0;
      else if (mode == 2) start = 1'($urandom_range(0, 1));
      if (ldA) begin
        obs_ops = {obs_ops[5:0], (add_sub ? 2'b10 : 2'b01)};
        nops++;
      end
      if (sftA) shifts++;
      if (done) begin
        got = 1;
        break;
      end
    end
    if (mode != 1) start = 1'b0;

    // Reference: bit pair (Q[i], Q[i-1]) = 10 -> subtract, 01 -> add.
    k = 0; exp_ops = '0; prev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (q[i] && !prev) begin exp_ops = {exp_ops[5:0], 2'b01}; k++; end
      if (!q[i] && prev) begin exp_ops = {exp_ops[5:0], 2'b10}; k++; end
      prev = q[i];
    end
    sm = $signed(m);
    sq = $signed(q);
    exp_prod = 8'(sm * sq);

    chk({tag, " done seen"}, 32'(got), 32'd1);
    chk({tag, " done cycle"}, 32'(cyc), 32'(3 + 3 * N + k));
    chk({tag, " product"}, {24'd0, dA, dQ}, {24'd0, exp_prod});
    chk({tag, " alu ops"}, {24'd0, obs_ops}, {24'd0, exp_ops});
    chk({tag, " alu count"}, 32'(nops), 32'(k));
    chk({tag, " shifts"}, 32'(shifts), 32'(N));
    chk({tag, " busy at done"}, {31'd0, busy}, 32'd0);
    chk({tag, " overlap"}, 32'(viol), 32'd0);
  endtask

  initial begin
    int         w;
    logic [3:0] rm, rq;

    rst = 1'b1; start = 1'b0; tb_m = '0; tb_q = '0;
    #12;
    chk("reset outputs", {18'd0, all_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle after reset", {18'd0, all_out}, 32'd0);

    run_mult(4'd7, 4'd0, 0, "zero mult", w);
    run_mult(4'd3, 4'd5, 0, "alternating", w);
    run_mult(4'hD, 4'd4, 0, "signed", w);

    // Reset inside the iteration loop.
    @(negedge clk);
    tb_m = 4'd5; tb_q = 4'd6; start = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("busy before reset", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("async reset outputs", {18'd0, all_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle after mid reset", {18'd0, all_out}, 32'd0);
    run_mult(4'd2, 4'd3, 0, "post reset", w);

    // Start held high: back-to-back with a single IDLE cycle between.
    run_mult(4'd6, 4'd3, 1, "hold 1", w);
    run_mult(4'hB, 4'd7, 1, "hold 2", w);
    chk("hold one idle", 32'(w), 32'd1);
    run_mult(4'd1, 4'hA, 1, "hold 3", w);
    chk("hold one idle 2", 32'(w), 32'd1);
    start = 1'b0;

    // Start toggled while busy.
    run_mult(4'd5, 4'hE, 2, "toggle", w);

    for (int t = 0; t < 10; t++) begin
      rm = 4'($urandom_range(0, 15));
      if (rm == 4'h8) rm = 4'h7;
      rq = 4'($urandom_range(0, 15));
      run_mult(rm, rq, (t % 2 == 0) ? 0 : 2, $sformatf("rand%0d", t), w);
    end

    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("final overlap", 32'(viol), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
